// File: rtl/wireframe_raster.sv
// wireframe_raster: draws a triangle's three edges into the 1-bit wireframe SRAM.
// Define WIREFRAME_CLEAR_EN to zero the triangle's rows before the edges are drawn.

module wireframe_raster #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [15:0]       v0_x,
  input  logic [15:0]       v0_y,
  input  logic [15:0]       v1_x,
  input  logic [15:0]       v1_y,
  input  logic [15:0]       v2_x,
  input  logic [15:0]       v2_y,
  input  logic              wf_ready,
  output logic              wf_we,
  output logic [ADDR_W-1:0] wf_addr,
  output logic              wf_wdata,
  output logic              busy,
  output logic              done,
  output logic [15:0]       min_y,
  output logic [15:0]       max_y
);

  typedef enum logic [2:0] {
    IDLE,
`ifdef WIREFRAME_CLEAR_EN
    CLEAR,
`endif
    LOAD,
    PLOT,
    DONE
  } state_t;

  state_t state, next_state;

  logic signed [15:0] vx [3];
  logic signed [15:0] vy [3];
  logic [1:0]         edge_q;
  logic signed [15:0] x_q, y_q;
  logic signed [17:0] dx_q, dy_q, err_q;
  logic               sx_q, sy_q;
  logic [ADDR_W-1:0]  addr_q;

  logic signed [15:0] ex0, ey0, ex1, ey1;
  logic signed [17:0] ddx, ddy, adx, ady;
  logic signed [18:0] e2, dx19, dy19;
  logic               step_x, step_y;
  logic               on_scr, accept, at_end;
  logic [ADDR_W-1:0]  pix_addr;
  logic [15:0]        in_min, in_max;

  function automatic logic signed [15:0] smin(
    input logic signed [15:0] a,
    input logic signed [15:0] b
  );
    return (a < b) ? a : b;
  endfunction

  function automatic logic signed [15:0] smax(
    input logic signed [15:0] a,
    input logic signed [15:0] b
  );
    return (a > b) ? a : b;
  endfunction

  function automatic logic [15:0] clamp_y(input logic signed [15:0] v);
    if (int'(v) < 0) return '0;
    if (int'(v) > HEIGHT - 1) return 16'(HEIGHT - 1);
    return v;
  endfunction

  assign in_min = clamp_y(smin(smin(v0_y, v1_y), v2_y));
  assign in_max = clamp_y(smax(smax(v0_y, v1_y), v2_y));

  always_comb begin
    ex0 = vx[2];
    ey0 = vy[2];
    ex1 = vx[0];
    ey1 = vy[0];
    unique case (edge_q)
      2'd0: begin
        ex0 = vx[0];
        ey0 = vy[0];
        ex1 = vx[1];
        ey1 = vy[1];
      end
      2'd1: begin
        ex0 = vx[1];
        ey0 = vy[1];
        ex1 = vx[2];
        ey1 = vy[2];
      end
      default: ;
    endcase
  end

  assign ddx = {{2{ex1[15]}}, ex1} - {{2{ex0[15]}}, ex0};
  assign ddy = {{2{ey1[15]}}, ey1} - {{2{ey0[15]}}, ey0};
  assign adx = ddx[17] ? -ddx : ddx;
  assign ady = ddy[17] ? -ddy : ddy;

  // both step tests look at the pre-step error term
  assign e2     = {err_q, 1'b0};
  assign dx19   = {dx_q[17], dx_q};
  assign dy19   = {dy_q[17], dy_q};
  assign step_x = e2 >= dy19;
  assign step_y = e2 <= dx19;

  assign on_scr = (int'(x_q) >= 0) && (int'(x_q) < WIDTH) &&
                  (int'(y_q) >= 0) && (int'(y_q) < HEIGHT);
  assign accept   = wf_ready || !on_scr;
  assign at_end   = (x_q == ex1) && (y_q == ey1);
  assign pix_addr = ADDR_W'(int'(y_q) * WIDTH + int'(x_q));

`ifdef WIREFRAME_CLEAR_EN
  logic [ADDR_W-1:0] clr_q, clr_first, clr_end;

  assign clr_first = ADDR_W'(int'(in_min) * WIDTH);
  assign clr_end   = ADDR_W'(int'(max_y) * WIDTH + WIDTH - 1);
`endif

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    wf_we      = 1'b0;
    wf_wdata   = 1'b0;
    wf_addr    = addr_q;
    unique case (state)
      IDLE: begin
`ifdef WIREFRAME_CLEAR_EN
        if (start) next_state = CLEAR;
`else
        if (start) next_state = LOAD;
`endif
      end
`ifdef WIREFRAME_CLEAR_EN
      CLEAR: begin
        wf_we   = 1'b1;
        wf_addr = clr_q;
        if (wf_ready && clr_q == clr_end) next_state = LOAD;
      end
`endif
      LOAD: next_state = PLOT;
      PLOT: begin
        wf_we    = on_scr;
        wf_wdata = 1'b1;
        wf_addr  = pix_addr;
        if (accept && at_end)
          next_state = (edge_q == 2'd2) ? DONE : LOAD;
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vx[0]  <= '0;
      vx[1]  <= '0;
      vx[2]  <= '0;
      vy[0]  <= '0;
      vy[1]  <= '0;
      vy[2]  <= '0;
      edge_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      dx_q   <= '0;
      dy_q   <= '0;
      err_q  <= '0;
      sx_q   <= 1'b0;
      sy_q   <= 1'b0;
      addr_q <= '0;
      min_y  <= '0;
      max_y  <= '0;
`ifdef WIREFRAME_CLEAR_EN
      clr_q  <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            vx[0]  <= v0_x;
            vx[1]  <= v1_x;
            vx[2]  <= v2_x;
            vy[0]  <= v0_y;
            vy[1]  <= v1_y;
            vy[2]  <= v2_y;
            min_y  <= in_min;
            max_y  <= in_max;
            edge_q <= 2'd0;
`ifdef WIREFRAME_CLEAR_EN
            clr_q  <= clr_first;
`endif
          end
        end
`ifdef WIREFRAME_CLEAR_EN
        CLEAR: begin
          addr_q <= wf_addr;
          if (wf_ready) clr_q <= clr_q + ADDR_W'(1);
        end
`endif
        LOAD: begin
          x_q   <= ex0;
          y_q   <= ey0;
          dx_q  <= adx;
          dy_q  <= -ady;
          err_q <= adx - ady;
          sx_q  <= ddx[17];
          sy_q  <= ddy[17];
        end
        PLOT: begin
          addr_q <= wf_addr;
          if (accept) begin
            if (at_end) begin
              if (edge_q != 2'd2) edge_q <= edge_q + 2'd1;
            end else begin
              err_q <= err_q + (step_x ? dy_q : 18'sd0)
                             + (step_y ? dx_q : 18'sd0);
              if (step_x) x_q <= sx_q ? x_q - 16'sd1 : x_q + 16'sd1;
              if (step_y) y_q <= sy_q ? y_q - 16'sd1 : y_q + 16'sd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wireframe_raster.sv
// tb_wireframe_raster: directed and randomized checks of wireframe_raster
// against a plain-integer Bresenham reference model.

module tb_wireframe_raster;

  localparam int W     = 640;
  localparam int H     = 480;
  localparam int LOGN  = 4096;
  localparam int BOUND = 60000;
`ifdef WIREFRAME_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] v0_x = '0, v0_y = '0, v1_x = '0;
  logic [15:0] v1_y = '0, v2_x = '0, v2_y = '0;
  logic        wf_ready = 1'b1;
  logic        wf_we, wf_wdata, busy, done;
  logic [18:0] wf_addr;
  logic [15:0] min_y, max_y;

  wireframe_raster #(.WIDTH(W), .HEIGHT(H), .ADDR_W(19)) dut (
    .clk(clk), .n_rst(n_rst), .start(start),
    .v0_x(v0_x), .v0_y(v0_y), .v1_x(v1_x),
    .v1_y(v1_y), .v2_x(v2_x), .v2_y(v2_y),
    .wf_ready(wf_ready), .wf_we(wf_we), .wf_addr(wf_addr),
    .wf_wdata(wf_wdata), .busy(busy), .done(done),
    .min_y(min_y), .max_y(max_y)
  );

  always #5 clk = ~clk;

  int nrun = 0;
  int nfail = 0;
  int cyc = 0;
  int t0 = 0;
  int stall_lo = 1;
  int stall_hi = 0;
  bit rand_ready = 1'b0;

  // writes are recorded as addr*2 + data
  int wq[$];
  int eq[$];
  bit log_we[LOGN];
  int log_addr[LOGN];
  bit log_busy[LOGN];
  bit log_done[LOGN];
  int m_done, m_min, m_max;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rand_ready)
      wf_ready = ($urandom_range(0, 3) != 0);
    else
      wf_ready = !((cyc - t0) >= stall_lo && (cyc - t0) <= stall_hi);
  end

  always @(negedge clk) begin
    int k;
    if (n_rst === 1'b1) begin
      k = cyc - t0;
      if (k >= 0 && k < LOGN) begin
        log_we[k]   = wf_we;
        log_addr[k] = int'(wf_addr);
        log_busy[k] = busy;
        log_done[k] = done;
      end
      if (wf_we === 1'b1 && wf_ready === 1'b1)
        wq.push_back(int'(wf_addr) * 2 + int'(wf_wdata));
    end
  end

  function automatic int clampi(input int v);
    if (v < 0) return 0;
    if (v > H - 1) return H - 1;
    return v;
  endfunction

  function automatic int first_diff();
    int n;
    n = (wq.size() < eq.size()) ? wq.size() : eq.size();
    for (int i = 0; i < n; i++)
      if (wq[i] != eq[i]) return i;
    if (wq.size() == eq.size()) return -1;
    return n;
  endfunction

  function automatic int wq_at(input int i);
    return (i >= 0 && i < wq.size()) ? wq[i] : -1;
  endfunction

  function automatic int eq_at(input int i);
    return (i >= 0 && i < eq.size()) ? eq[i] : -1;
  endfunction

  task automatic add_clear(input int r0, input int r1);
    for (int r = r0; r <= r1; r++)
      for (int c = 0; c < W; c++)
        eq.push_back((r * W + c) * 2);
  endtask

  // reference: classic integer Bresenham per edge, on-screen pixels only
  task automatic model(input int ax, input int ay, input int bx,
                       input int by, input int cx, input int cy);
    int px[3];
    int py[3];
    int x, y, x1, y1, dx, dy, sx, sy, err, e2, npix, nclr;
    px = '{ax, bx, cx};
    py = '{ay, by, cy};
    eq.delete();
    m_min = clampi((ay < by) ? ((ay < cy) ? ay : cy) : ((by < cy) ? by : cy));
    m_max = clampi((ay > by) ? ((ay > cy) ? ay : cy) : ((by > cy) ? by : cy));
    nclr = 0;
    if (CLR) begin
      add_clear(m_min, m_max);
      nclr = (m_max - m_min + 1) * W;
    end
    npix = 0;
    for (int e = 0; e < 3; e++) begin
      x  = px[e];
      y  = py[e];
      x1 = px[(e + 1) % 3];
      y1 = py[(e + 1) % 3];
      dx = (x1 > x) ? x1 - x : x - x1;
      dy = (y1 > y) ? y - y1 : y1 - y;
      sx = (x1 >= x) ? 1 : -1;
      sy = (y1 >= y) ? 1 : -1;
      err = dx + dy;
      forever begin
        npix++;
        if (x >= 0 && x < W && y >= 0 && y < H)
          eq.push_back((y * W + x) * 2 + 1);
        if (x == x1 && y == y1) break;
        e2 = 2 * err;
        if (e2 >= dy) begin err += dy; x += sx; end
        if (e2 <= dx) begin err += dx; y += sy; end
      end
    end
    m_done = 1 + nclr + 3 + npix;
  endtask

  task automatic kick(input int ax, input int ay, input int bx,
                      input int by, input int cx, input int cy);
    @(posedge clk);
    #2;
    t0 = cyc;
    wq.delete();
    for (int i = 0; i < LOGN; i++) begin
      log_we[i]   = 1'b0;
      log_addr[i] = 0;
      log_busy[i] = 1'b0;
      log_done[i] = 1'b0;
    end
    v0_x = 16'(ax); v0_y = 16'(ay);
    v1_x = 16'(bx); v1_y = 16'(by);
    v2_x = 16'(cx); v2_y = 16'(cy);
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  task automatic run_tri(input int ax, input int ay, input int bx,
                         input int by, input int cx, input int cy,
                         input int rk, output int dcyc);
    kick(ax, ay, bx, by, cx, cy);
    dcyc = -1;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (rk >= 0 && cyc - t0 == rk) begin
        start = 1'b1;
        v0_x = 16'd100;
        v1_x = 16'd200;
        v2_y = 16'd300;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        dcyc = cyc - t0;
        break;
      end
    end
    start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nrun++;
    if ({wf_we, wf_wdata, busy, done} !== 4'b0 || wf_addr !== '0 ||
        min_y !== '0 || max_y !== '0) begin
      nfail++;
      $display("FAIL reset_outputs: we=%b data=%b busy=%b done=%b addr=%0d min=%0d max=%0d, required all 0",
               wf_we, wf_wdata, busy, done, wf_addr, min_y, max_y);
    end
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    nrun++;
    if (busy !== 1'b0 || wq.size() != 0) begin
      nfail++;
      $display("FAIL reset_idle: busy=%b writes=%0d, required busy=0 writes=0", busy, wq.size());
    end
  endtask

  task automatic test_basic();
    int ref_edge[12] = '{0, 1, 2, 3, 3, 642, 1281, 1920, 1920, 1280, 640, 0};
    int c, d, fd, bad, nd;
    c = CLR ? 2560 : 0;
    eq.delete();
    if (CLR) add_clear(0, 3);
    foreach (ref_edge[i]) eq.push_back(ref_edge[i] * 2 + 1);
    run_tri(0, 0, 3, 0, 0, 3, -1, d);
    fd = first_diff();
    nrun++;
    if (fd >= 0) begin
      nfail++;
      $display("FAIL basic_writes: idx %0d got %0d required %0d (count %0d vs %0d)",
               fd, wq_at(fd), eq_at(fd), wq.size(), eq.size());
    end
    nrun++;
    if (d != 16 + c) begin
      nfail++;
      $display("FAIL basic_done_cycle: got %0d required %0d", d, 16 + c);
    end
    nrun++;
    if (min_y !== 16'd0 || max_y !== 16'd3) begin
      nfail++;
      $display("FAIL basic_rows: got %0d..%0d required 0..3", min_y, max_y);
    end
    bad = 0;
    nd = 0;
    for (int k = 0; k <= 17 + c; k++) begin
      if (log_busy[k] != (k >= 1 && k <= 16 + c)) bad++;
      if (log_done[k]) nd++;
    end
    nrun++;
    if (bad != 0) begin
      nfail++;
      $display("FAIL basic_busy: %0d cycles wrong, required high exactly 1..%0d", bad, 16 + c);
    end
    nrun++;
    if (nd != 1 || !log_done[16 + c]) begin
      nfail++;
      $display("FAIL basic_done_pulse: got %0d pulses, required 1 at cycle %0d", nd, 16 + c);
    end
  endtask

  task automatic test_stall();
    int c, d, fd, bad;
    c = CLR ? 2560 : 0;
    stall_lo = 8 + c;
    stall_hi = 10 + c;
    eq.delete();
    if (CLR) add_clear(0, 3);
    model(0, 0, 3, 0, 0, 3);
    run_tri(0, 0, 3, 0, 0, 3, -1, d);
    stall_lo = 1;
    stall_hi = 0;
    fd = first_diff();
    nrun++;
    if (fd >= 0) begin
      nfail++;
      $display("FAIL stall_writes: idx %0d got %0d required %0d (count %0d vs %0d)",
               fd, wq_at(fd), eq_at(fd), wq.size(), eq.size());
    end
    nrun++;
    if (d != 19 + c) begin
      nfail++;
      $display("FAIL stall_done_cycle: got %0d required %0d", d, 19 + c);
    end
    bad = 0;
    for (int k = 8 + c; k <= 11 + c; k++)
      if (!log_we[k] || log_addr[k] != 642) bad++;
    nrun++;
    if (bad != 0) begin
      nfail++;
      $display("FAIL stall_hold: %0d cycles not presenting addr 642 (cycle %0d addr %0d), required 0",
               bad, 9 + c, log_addr[9 + c]);
    end
  endtask

  task automatic test_clip();
    int ref_edge[6] = '{0, 1, 1, 641, 641, 640};
    int c, d, fd;
    c = CLR ? 1280 : 0;
    eq.delete();
    if (CLR) add_clear(0, 1);
    foreach (ref_edge[i]) eq.push_back(ref_edge[i] * 2 + 1);
    run_tri(-2, 0, 1, 0, 1, 1, -1, d);
    fd = first_diff();
    nrun++;
    if (fd >= 0) begin
      nfail++;
      $display("FAIL clip_writes: idx %0d got %0d required %0d (count %0d vs %0d)",
               fd, wq_at(fd), eq_at(fd), wq.size(), eq.size());
    end
    nrun++;
    if (d != 14 + c) begin
      nfail++;
      $display("FAIL clip_done_cycle: got %0d required %0d", d, 14 + c);
    end
    nrun++;
    if (min_y !== 16'd0 || max_y !== 16'd1) begin
      nfail++;
      $display("FAIL clip_rows: got %0d..%0d required 0..1", min_y, max_y);
    end
  endtask

  task automatic test_degenerate();
    int c, d, fd, nb, n0;
    c = CLR ? 640 : 0;
    eq.delete();
    if (CLR) add_clear(5, 5);
    repeat (3) eq.push_back(3205 * 2 + 1);
    run_tri(5, 5, 5, 5, 5, 5, 3, d);
    fd = first_diff();
    nrun++;
    if (fd >= 0) begin
      nfail++;
      $display("FAIL degen_writes: idx %0d got %0d required %0d (count %0d vs %0d)",
               fd, wq_at(fd), eq_at(fd), wq.size(), eq.size());
    end
    nrun++;
    if (d != 7 + c) begin
      nfail++;
      $display("FAIL degen_done_cycle: got %0d required %0d", d, 7 + c);
    end
    n0 = wq.size();
    nb = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy !== 1'b0) nb++;
    end
    nrun++;
    if (nb != 0 || wq.size() != n0 || min_y !== 16'd5 || max_y !== 16'd5) begin
      nfail++;
      $display("FAIL degen_restart_ignored: busy cycles %0d extra writes %0d rows %0d..%0d, required 0 0 5..5",
               nb, wq.size() - n0, min_y, max_y);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    c = CLR ? 2560 : 0;
    kick(0, 2, 3, 2, 0, 5);
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (cyc - t0 >= 8 + c) break;
    end
    nrun++;
    if (min_y !== 16'd2 || max_y !== 16'd5 || busy !== 1'b1) begin
      nfail++;
      $display("FAIL midreset_pre: rows %0d..%0d busy=%b, required 2..5 busy=1", min_y, max_y, busy);
    end
    n_rst = 1'b0;
    #1;
    nrun++;
    if ({wf_we, wf_wdata, busy, done} !== 4'b0 || wf_addr !== '0 ||
        min_y !== '0 || max_y !== '0) begin
      nfail++;
      $display("FAIL midreset_outputs: we=%b data=%b busy=%b done=%b addr=%0d min=%0d max=%0d, required all 0",
               wf_we, wf_wdata, busy, done, wf_addr, min_y, max_y);
    end
    wq.delete();
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    repeat (20) @(negedge clk);
    nrun++;
    if (wq.size() != 0 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL midreset_quiet: writes=%0d busy=%b, required 0 and 0", wq.size(), busy);
    end
  endtask

  task automatic test_random();
    int n, bx, by, ys, d, fd;
    int vx[3];
    int vy[3];
    n = CLR ? 4 : 16;
    for (int it = 0; it < n; it++) begin
      bx = int'($urandom_range(0, W + 60)) - 30;
      by = int'($urandom_range(0, H + 40)) - 20;
      ys = CLR ? 8 : 60;
      for (int j = 0; j < 3; j++) begin
        vx[j] = bx + int'($urandom_range(0, 80)) - 40;
        vy[j] = by + int'($urandom_range(0, ys)) - ys / 2;
      end
      rand_ready = it[0];
      model(vx[0], vy[0], vx[1], vy[1], vx[2], vy[2]);
      run_tri(vx[0], vy[0], vx[1], vy[1], vx[2], vy[2], -1, d);
      rand_ready = 1'b0;
      fd = first_diff();
      nrun++;
      if (fd >= 0) begin
        nfail++;
        $display("FAIL rand%0d_writes: idx %0d got %0d required %0d (count %0d vs %0d)",
                 it, fd, wq_at(fd), eq_at(fd), wq.size(), eq.size());
      end
      nrun++;
      if (min_y !== 16'(m_min) || max_y !== 16'(m_max)) begin
        nfail++;
        $display("FAIL rand%0d_rows: got %0d..%0d required %0d..%0d",
                 it, min_y, max_y, m_min, m_max);
      end
      nrun++;
      if (it[0] ? (d < m_done) : (d != m_done)) begin
        nfail++;
        $display("FAIL rand%0d_done_cycle: got %0d required %0d%s",
                 it, d, m_done, it[0] ? " or later" : "");
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_clip();
    test_degenerate();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule

// File: doc/wireframe_raster.md
Name: wireframe_raster

Overview:
- Upstream stage of the scanline colour fill. It takes one triangle's screen-space vertices and draws its three edges into the 1-bit wireframe SRAM using integer Bresenham, one pixel per accepted cycle.
- The fill stage later scans each row of that SRAM for its leftmost and rightmost set bits.
- The block also reports the triangle's clamped row range, so the row sequencer knows which heights to fill.

Parameters:
- WIDTH, 640, screen width in pixels; row stride of the wireframe SRAM.
- HEIGHT, 480, screen height in pixels.
- ADDR_W, 19, wireframe SRAM address width (equals `WIREFRAME_ADDR_SIZE).

Ports:
- clk  input  1  clock.
- n_rst  input  1  reset, asynchronous, active-low.
- start  input  1  single-cycle request; vertices are latched on it.
- v0_x, v0_y, v1_x, v1_y, v2_x, v2_y  input  16 each  signed vertex coordinates (shortint); z is not used.
- wf_ready  input  1  SRAM arbiter accepts this cycle's write.
- wf_we  output  1  wireframe write strobe.
- wf_addr  output  ADDR_W  write address = y*WIDTH + x.
- wf_wdata  output  1  written bit.
- busy  output  1  high from the cycle after an accepted start through DONE.
- done  output  1  one-cycle pulse when the triangle is complete.
- min_y, max_y  output  16 each  row range clamped to [0, HEIGHT-1].

Behaviour:
- Reset values: all outputs 0; state IDLE; internal x, y, err, edge index all 0. Asserting reset mid-operation aborts immediately; no further writes occur.
- States: IDLE, (CLEAR), LOAD, PLOT, DONE.
- IDLE:
  - On start, latch the vertices.
  - Register min_y/max_y = clamp(min/max of v*_y, 0, HEIGHT-1).
  - Set edge index to 0 and go to LOAD (or CLEAR when the feature is enabled).
  - start is ignored while busy.
- Edge order: edge 0 = v0->v1, edge 1 = v1->v2, edge 2 = v2->v0.
- LOAD (1 cycle): for edge (x0,y0)->(x1,y1) set:
  - x = x0, y = y0
  - dx = |x1-x0|, dy = -|y1-y0|
  - sx = sign(x1-x0) (+1 if equal), sy likewise
  - err = dx + dy
  - No write occurs in LOAD.
- PLOT:
  - Drive wf_addr = y*WIDTH + x and wf_wdata = 1.
  - Drive wf_we = 1 only if 0 <= x < WIDTH and 0 <= y < HEIGHT.
  - The pixel is accepted when wf_ready = 1 or the pixel is off-screen (clipped pixels consume one cycle and no write).
  - If not accepted: hold all outputs and registers.
  - If accepted and (x,y) == (x1,y1): go to LOAD of the next edge, or to DONE after edge 2.
  - Otherwise step, with e2 = 2*err:
    - if e2 >= dy: err += dy, x += sx
    - if e2 <= dx: err += dx, y += sy
    - Both updates use the pre-step err, so the net change is the sum.
- Widths: dx, dy and err are 18-bit signed; e2 is 19-bit signed. No overflow occurs for 16-bit inputs.
- Each edge plots max(|dx|,|dy|)+1 pixels. Shared vertices are written twice; this is harmless.
- DONE (1 cycle): done = 1, busy = 1; next state IDLE. min_y/max_y hold until the next start.
- Degenerate triangle (all vertices equal): three plots to the same address.
- Off-screen triangle: zero writes; done still pulses.
- wf_we never asserts outside PLOT (or CLEAR). wf_addr is don't-care when wf_we = 0, but must be deterministic (hold the last value).

Optional Feature:
- Macro WIREFRAME_CLEAR_EN.
- When defined: after start, enter CLEAR before the first LOAD.
  - Write wf_wdata = 0 to every address of rows min_y..max_y, x = 0..WIDTH-1, in ascending address order.
  - One address per cycle with wf_ready = 1; the address is held while wf_ready = 0.
  - After address max_y*WIDTH + WIDTH-1 is accepted, go to LOAD.
- When undefined: IDLE goes directly to LOAD; no clear writes occur and the CLEAR state does not exist.

Test Plan:
- Triangle (0,0),(3,0),(0,3), wf_ready = 1, start at cycle 0:
  - Write addresses in order: 0,1,2,3; 3,642,1281,1920; 1920,1280,640,0.
  - done high at cycle 16.
  - min_y = 0, max_y = 3.
  - busy high cycles 1..16.
- Same triangle with wf_ready = 0 for 3 cycles while addr 642 is presented: addr/we held; sequence unchanged; done delayed to cycle 19.
- Triangle (-2,0),(1,0),(1,1):
  - Pixels x = -2, -1 produce no wf_we and cost 1 cycle each.
  - Writes: 0,1; 1,641; 641,640.
  - min_y = 0, max_y = 1.
- All vertices (5,5): three writes to addr 3205, then done. start pulsed again while busy: ignored.
- Assert n_rst low during edge 1: outputs go to 0 immediately; after release, no writes until a new start.
- With WIREFRAME_CLEAR_EN, first triangle:
  - 2560 writes of 0 to addresses 0..2559 precede the 12 edge writes.
  - done at cycle 2576.
